// File: rtl/axi_10g_ethernet_0_rx_arbiter.sv
// ---------------------------------------------------------------------------
// axi_10g_ethernet_0_rx_arbiter
//
// Packet-granular arbiter that shares the 64-bit RX user stream between the
// RAM replay source and the live FIFO source. One source is granted for a
// whole packet (through its tlast beat), so beats of the two sources are never
// interleaved. The user-side stream is driven from an output register, and
// both sources see full AXI-Stream backpressure through their tready.
//
// Parameters
//   ROUND_ROBIN  0: RAM always wins contention; 1: alternate winner on contention
//   CNT_W        width of the per-source packet counters (wrap modulo 2^CNT_W)
//
// Ports
//   aclk, areset              clock, synchronous active-high reset
//   rx_user_ram_*             RAM source stream (tdata/tkeep/tlast/tvalid in, tready out)
//   rx_user_fifo_*            FIFO source stream (tdata/tkeep/tlast/tvalid in, tready out)
//   rx_user_*                 registered user stream (tready in)
//   ram_pkt_cnt, fifo_pkt_cnt packets forwarded from each source
//
// Timing
//   One idle arbitration cycle precedes every packet. Inside a packet an
//   accepted source beat appears on the user port one cycle later, and beats
//   can be accepted back to back while the user keeps tready high.
// ---------------------------------------------------------------------------
module axi_10g_ethernet_0_rx_arbiter #(
  parameter int ROUND_ROBIN = 0,
  parameter int CNT_W       = 32
) (
  input  logic             aclk,
  input  logic             areset,

  input  logic [63:0]      rx_user_ram_tdata,
  input  logic [7:0]       rx_user_ram_tkeep,
  input  logic             rx_user_ram_tlast,
  input  logic             rx_user_ram_tvalid,
  output logic             rx_user_ram_tready,

  input  logic [63:0]      rx_user_fifo_tdata,
  input  logic [7:0]       rx_user_fifo_tkeep,
  input  logic             rx_user_fifo_tlast,
  input  logic             rx_user_fifo_tvalid,
  output logic             rx_user_fifo_tready,

  output logic [63:0]      rx_user_tdata,
  output logic [7:0]       rx_user_tkeep,
  output logic             rx_user_tlast,
  output logic             rx_user_tvalid,
  input  logic             rx_user_tready,

  output logic [CNT_W-1:0] ram_pkt_cnt,
  output logic [CNT_W-1:0] fifo_pkt_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GNT_RAM  = 2'd1,
    ST_GNT_FIFO = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_fifo;   // 1: the most recent grant went to the FIFO source

  logic [63:0]      r_tdata;
  logic [7:0]       r_tkeep;
  logic             r_tlast;
  logic             r_tvalid;

  logic [CNT_W-1:0] r_ram_cnt;
  logic [CNT_W-1:0] r_fifo_cnt;

  logic             w_out_free;
  logic             w_ram_tready;
  logic             w_fifo_tready;
  logic             w_ram_acc;
  logic             w_fifo_acc;
  logic             w_contend_fifo;

  // The output register can take a new beat when it is empty or when its
  // current beat leaves on this edge.
  assign w_out_free = !r_tvalid || rx_user_tready;

  assign w_ram_acc  = rx_user_ram_tvalid  && w_ram_tready;
  assign w_fifo_acc = rx_user_fifo_tvalid && w_fifo_tready;

  // On contention the FIFO wins only in round-robin mode and only when the RAM
  // source took the previous grant.
  assign w_contend_fifo = (ROUND_ROBIN != 0) && !r_last_fifo;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: every clocked register uses non-blocking assignments so all flops
  // sample the pre-edge values of each other, independent of block order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= ST_IDLE;
      r_last_fifo <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      // The winner is remembered at the moment a grant is issued from IDLE.
      if (r_state == ST_IDLE && w_state_nxt == ST_GNT_RAM) begin
        r_last_fifo <= 1'b0;
      end else if (r_state == ST_IDLE && w_state_nxt == ST_GNT_FIFO) begin
        r_last_fifo <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block purely
  // combinational; without it an unassigned path would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_user_ram_tvalid && rx_user_fifo_tvalid) begin
          w_state_nxt = w_contend_fifo ? ST_GNT_FIFO : ST_GNT_RAM;
        end else if (rx_user_ram_tvalid) begin
          w_state_nxt = ST_GNT_RAM;
        end else if (rx_user_fifo_tvalid) begin
          w_state_nxt = ST_GNT_FIFO;
        end
      end
      // The grant is held through gaps in the granted stream; only an
      // accepted tlast beat releases it.
      ST_GNT_RAM: begin
        if (w_ram_acc && rx_user_ram_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GNT_FIFO: begin
        if (w_fifo_acc && rx_user_fifo_tlast) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output logic (source backpressure)
  // -------------------------------------------------------------------------
  // Only the granted source ever sees tready; IDLE is a closed bubble.
  always_comb begin
    w_ram_tready  = 1'b0;
    w_fifo_tready = 1'b0;
    case (r_state)
      ST_GNT_RAM:  w_ram_tready  = w_out_free;
      ST_GNT_FIFO: w_fifo_tready = w_out_free;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  // At most one accept strobe can be high because tready is only given to the
  // granted source. With no accept the held beat stays stable until the user
  // takes it, then tvalid drops.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tdata  <= '0;
      r_tkeep  <= '0;
      r_tlast  <= 1'b0;
      r_tvalid <= 1'b0;
    end else if (w_ram_acc) begin
      r_tdata  <= rx_user_ram_tdata;
      r_tkeep  <= rx_user_ram_tkeep;
      r_tlast  <= rx_user_ram_tlast;
      r_tvalid <= 1'b1;
    end else if (w_fifo_acc) begin
      r_tdata  <= rx_user_fifo_tdata;
      r_tkeep  <= rx_user_fifo_tkeep;
      r_tlast  <= rx_user_fifo_tlast;
      r_tvalid <= 1'b1;
    end else if (rx_user_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Packet counters: counted when the tlast beat is accepted from the source,
  // on the same edge the grant is released. They wrap naturally.
  // -------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_ram_cnt  <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_ram_acc && rx_user_ram_tlast) begin
        r_ram_cnt <= r_ram_cnt + CNT_W'(1);
      end
      if (w_fifo_acc && rx_user_fifo_tlast) begin
        r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
      end
    end
  end

  assign rx_user_ram_tready  = w_ram_tready;
  assign rx_user_fifo_tready = w_fifo_tready;

  assign rx_user_tdata  = r_tdata;
  assign rx_user_tkeep  = r_tkeep;
  assign rx_user_tlast  = r_tlast;
  assign rx_user_tvalid = r_tvalid;

  assign ram_pkt_cnt  = r_ram_cnt;
  assign fifo_pkt_cnt = r_fifo_cnt;

endmodule

// File: tb/tb_axi_10g_ethernet_0_rx_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for axi_10g_ethernet_0_rx_arbiter.
//
// Two instances run side by side with independent stimulus: instance 0 uses
// fixed RAM priority, instance 1 uses round robin. Both use a 4-bit counter so
// packet counters wrap within a short run. Source drivers send random packets
// (random length, gaps, tkeep) with AXI-Stream hold-until-accepted behaviour;
// the user side applies random backpressure and 4-cycle stalls.
//
// A reference model follows the arbitration rules (who owns the stream, is
// the output register occupied, packet tallies) and pushes every beat it
// expects the user port to carry into a per-instance queue. A separate monitor
// pops and compares whenever a user handshake happens.
// ---------------------------------------------------------------------------
module tb_axi_10g_ethernet_0_rx_arbiter;

  localparam int NDUT  = 2;
  localparam int CNT_W = 4;
  localparam int RAM   = 0;
  localparam int FIFO  = 1;
  localparam int NONE  = -1;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic aclk   = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  // Source side, index [instance][RAM/FIFO]
  logic [63:0]      s_tdata [NDUT][2];
  logic [7:0]       s_tkeep [NDUT][2];
  logic             s_tlast [NDUT][2];
  logic             s_tvalid[NDUT][2];
  logic             s_tready[NDUT][2];
  // User side
  logic [63:0]      u_tdata [NDUT];
  logic [7:0]       u_tkeep [NDUT];
  logic             u_tlast [NDUT];
  logic             u_tvalid[NDUT];
  logic             u_tready[NDUT];
  logic [CNT_W-1:0] u_cnt   [NDUT][2];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    axi_10g_ethernet_0_rx_arbiter #(
      .ROUND_ROBIN(g),
      .CNT_W      (CNT_W)
    ) u_dut (
      .aclk               (aclk),
      .areset             (areset),
      .rx_user_ram_tdata  (s_tdata[g][0]),
      .rx_user_ram_tkeep  (s_tkeep[g][0]),
      .rx_user_ram_tlast  (s_tlast[g][0]),
      .rx_user_ram_tvalid (s_tvalid[g][0]),
      .rx_user_ram_tready (s_tready[g][0]),
      .rx_user_fifo_tdata (s_tdata[g][1]),
      .rx_user_fifo_tkeep (s_tkeep[g][1]),
      .rx_user_fifo_tlast (s_tlast[g][1]),
      .rx_user_fifo_tvalid(s_tvalid[g][1]),
      .rx_user_fifo_tready(s_tready[g][1]),
      .rx_user_tdata      (u_tdata[g]),
      .rx_user_tkeep      (u_tkeep[g]),
      .rx_user_tlast      (u_tlast[g]),
      .rx_user_tvalid     (u_tvalid[g]),
      .rx_user_tready     (u_tready[g]),
      .ram_pkt_cnt        (u_cnt[g][0]),
      .fifo_pkt_cnt       (u_cnt[g][1])
    );
  end

  // ---------------------------------------------------------------------------
  // Checking bookkeeping
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  beat_t exp_q[NDUT][$];

  // ---------------------------------------------------------------------------
  // Stimulus knobs and driver state
  // ---------------------------------------------------------------------------
  int len_min   = 1;
  int len_max   = 1;
  int gap_pct   = 0;
  int rdy_pct   = 100;
  int stall_pct = 0;
  int budget[NDUT][2];   // packets still to be started per source
  int rem   [NDUT][2];   // beats left in the current packet, including the one shown
  int beat  [NDUT][2];
  int pid   [NDUT][2];
  int stall [NDUT];

  bit hs[NDUT][2];       // source handshake seen just before the coming edge
  bit rst_edge;          // areset seen just before the coming edge

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  int m_own  [NDUT];     // source owning the user stream, NONE while arbitrating
  bit m_lastf[NDUT];     // last grant went to the FIFO
  bit m_full [NDUT];     // user output register holds a beat
  int m_cnt  [NDUT][2];
  bit m_jr   [NDUT];     // a reset edge just happened
  bit flush  [NDUT];

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      m_own[d] = NONE; m_lastf[d] = 1'b1; m_full[d] = 1'b0; m_jr[d] = 1'b1;
      flush[d] = 1'b0; stall[d] = 0; u_tready[d] = 1'b1;
      for (int s = 0; s < 2; s++) begin
        m_cnt[d][s] = 0; budget[d][s] = 0; rem[d][s] = 0; beat[d][s] = 0; pid[d][s] = 0;
        hs[d][s] = 1'b0;
        s_tdata[d][s] = '0; s_tkeep[d][s] = '0; s_tlast[d][s] = 1'b0; s_tvalid[d][s] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Source and user drivers: update just after each rising edge
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      for (int d = 0; d < NDUT; d++) begin
        for (int s = 0; s < 2; s++) begin
          if (rst_edge) begin
            // Sources are reset alongside the arbiter: the partial packet is gone.
            rem[d][s] = 0;
            s_tvalid[d][s] = 1'b0;
            s_tlast[d][s]  = 1'b0;
          end else begin
            if (s_tvalid[d][s] && hs[d][s]) begin
              beat[d][s]++;
              rem[d][s]--;
              s_tvalid[d][s] = 1'b0;
            end
            if (!s_tvalid[d][s]) begin
              if (rem[d][s] == 0 && budget[d][s] > 0) begin
                budget[d][s]--;
                pid[d][s]++;
                beat[d][s] = 0;
                rem[d][s]  = $urandom_range(len_max, len_min);
              end
              if (rem[d][s] > 0 && $urandom_range(99) >= gap_pct) begin
                s_tvalid[d][s] = 1'b1;
                s_tdata[d][s]  = {8'(s + 1), 8'(d), 16'(pid[d][s]), 8'(beat[d][s]), 24'($urandom)};
                s_tkeep[d][s]  = 8'($urandom);
                s_tlast[d][s]  = (rem[d][s] == 1);
              end
            end
          end
        end
        if (stall[d] == 0 && stall_pct > 0 && $urandom_range(99) < stall_pct) stall[d] = 4;
        if (stall[d] > 0) begin
          u_tready[d] = 1'b0;
          stall[d]--;
        end else begin
          u_tready[d] = ($urandom_range(99) < rdy_pct);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: evaluated mid-cycle, advances to the state after the
  // coming edge and predicts which source beats get accepted.
  // ---------------------------------------------------------------------------
  initial begin
    bit rdy[2];
    bit acc[2];
    int w;
    beat_t b;
    forever begin
      @(negedge aclk);
      rst_edge = areset;
      for (int d = 0; d < NDUT; d++) begin
        for (int s = 0; s < 2; s++) hs[d][s] = s_tvalid[d][s] && s_tready[d][s];

        if (m_jr[d]) begin
          check($sformatf("d%0d_rst_tdata", d), u_tdata[d], 0);
          check($sformatf("d%0d_rst_tkeep", d), u_tkeep[d], 0);
          check($sformatf("d%0d_rst_tlast", d), u_tlast[d], 0);
          m_jr[d] = 1'b0;
        end

        for (int s = 0; s < 2; s++) begin
          rdy[s] = (m_own[d] == s) && (!m_full[d] || u_tready[d]);
          acc[s] = rdy[s] && s_tvalid[d][s];
        end
        check($sformatf("d%0d_ram_tready", d),  s_tready[d][0], rdy[0]);
        check($sformatf("d%0d_fifo_tready", d), s_tready[d][1], rdy[1]);
        check($sformatf("d%0d_user_tvalid", d), u_tvalid[d], m_full[d]);
        check($sformatf("d%0d_ram_pkt_cnt", d),  u_cnt[d][0], m_cnt[d][0]);
        check($sformatf("d%0d_fifo_pkt_cnt", d), u_cnt[d][1], m_cnt[d][1]);

        if (areset) begin
          m_own[d] = NONE; m_lastf[d] = 1'b1; m_full[d] = 1'b0;
          m_cnt[d][0] = 0; m_cnt[d][1] = 0;
          m_jr[d] = 1'b1; flush[d] = 1'b1;
        end else begin
          for (int s = 0; s < 2; s++) begin
            if (acc[s]) begin
              b.data = s_tdata[d][s];
              b.keep = s_tkeep[d][s];
              b.last = s_tlast[d][s];
              exp_q[d].push_back(b);
            end
          end
          if (acc[0] || acc[1]) m_full[d] = 1'b1;
          else if (u_tready[d]) m_full[d] = 1'b0;

          if (m_own[d] == NONE) begin
            if (s_tvalid[d][0] && s_tvalid[d][1]) w = (d == 1 && !m_lastf[d]) ? FIFO : RAM;
            else if (s_tvalid[d][0]) w = RAM;
            else if (s_tvalid[d][1]) w = FIFO;
            else w = NONE;
            if (w != NONE) begin
              m_own[d]   = w;
              m_lastf[d] = (w == FIFO);
            end
          end else if (acc[m_own[d]] && s_tlast[d][m_own[d]]) begin
            m_cnt[d][m_own[d]] = (m_cnt[d][m_own[d]] + 1) % (1 << CNT_W);
            m_own[d] = NONE;
          end
        end
      end
    end
  end

  // Beats expected but not yet delivered when a reset hits are dropped.
  initial begin
    forever begin
      @(posedge aclk);
      for (int d = 0; d < NDUT; d++) begin
        if (flush[d]) begin
          exp_q[d].delete();
          flush[d] = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare every user-side handshake against the scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    beat_t e;
    forever begin
      @(negedge aclk);
      for (int d = 0; d < NDUT; d++) begin
        if (u_tvalid[d] === 1'b1 && u_tready[d]) begin
          if (exp_q[d].size() == 0) begin
            check($sformatf("d%0d_unexpected_beat", d), u_tvalid[d], 0);
          end else begin
            e = exp_q[d].pop_front();
            check($sformatf("d%0d_beat", d), {u_tdata[d], u_tkeep[d], u_tlast[d]}, e);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Phase control
  // ---------------------------------------------------------------------------
  function automatic bit all_idle();
    bit idle = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      if (u_tvalid[d] !== 1'b0 || exp_q[d].size() != 0) idle = 1'b0;
      for (int s = 0; s < 2; s++)
        if (budget[d][s] != 0 || rem[d][s] != 0 || s_tvalid[d][s]) idle = 1'b0;
    end
    return idle;
  endfunction

  task automatic set_phase(input int lmin, input int lmax, input int gap, input int rdy,
                           input int stl, input int n_ram, input int n_fifo);
    len_min = lmin; len_max = lmax; gap_pct = gap; rdy_pct = rdy; stall_pct = stl;
    for (int d = 0; d < NDUT; d++) begin
      budget[d][0] = n_ram;
      budget[d][1] = n_fifo;
    end
  endtask

  task automatic drain(input string name, input int bound);
    int n = 0;
    while (!all_idle() && n < bound) begin
      @(negedge aclk);
      n++;
      if (n > bound / 2) begin
        rdy_pct = 100; stall_pct = 0; gap_pct = 0;
      end
    end
    if (n >= bound) check({name, "_drain_timeout"}, all_idle(), 1);
    repeat (2) @(negedge aclk);
  endtask

  initial begin
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;

    // Single 3-beat RAM packet with an always-ready user.
    set_phase(3, 3, 0, 100, 0, 1, 0);
    drain("single_ram", 200);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_single_ram_cnt", d), u_cnt[d][0], 1);
      check($sformatf("d%0d_single_fifo_cnt", d), u_cnt[d][1], 0);
    end

    // Both sources raise 2-beat packets together.
    set_phase(2, 2, 0, 100, 0, 1, 1);
    drain("contend", 200);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_contend_ram_cnt", d), u_cnt[d][0], 2);
      check($sformatf("d%0d_contend_fifo_cnt", d), u_cnt[d][1], 1);
    end

    // Continuous 1-beat packets on both sources.
    set_phase(1, 1, 0, 100, 0, 10, 10);
    drain("stream", 400);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_stream_ram_cnt", d), u_cnt[d][0], 12);
      check($sformatf("d%0d_stream_fifo_cnt", d), u_cnt[d][1], 11);
    end

    // Random lengths, mid-packet source gaps, random backpressure and stalls.
    set_phase(1, 6, 30, 70, 5, 20, 20);
    drain("random", 6000);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("d%0d_random_ram_cnt", d), u_cnt[d][0], 0);
      check($sformatf("d%0d_random_fifo_cnt", d), u_cnt[d][1], 15);
    end

    // Reset in the middle of a packet, then continue with fresh traffic.
    @(posedge aclk);
    #1 set_phase(5, 5, 0, 100, 0, 3, 3);
    repeat (5) @(posedge aclk);
    #1 areset = 1'b1;
    @(posedge aclk);
    #1 areset = 1'b0;
    drain("reset", 1000);

    // Enough traffic after the reset for both counters to wrap again.
    set_phase(1, 3, 20, 80, 3, 20, 20);
    drain("wrap", 6000);
    for (int d = 0; d < NDUT; d++)
      check($sformatf("d%0d_queue_empty", d), exp_q[d].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
